// File: rtl/thread_issue_queue.sv
// Two-thread issue queue: per-thread FIFOs, round-robin issue through a registered valid/ready stage,
// and a thread-1 control-flow pending flag. Optional macro ISSUE_PERF_CNT_EN adds per-thread issue counters.
module thread_issue_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_instr,
  input  logic        in_valid,
  input  logic        in_thread,
  output logic        full_1,
  output logic        full_2,
  output logic        ovf_1,
  output logic        ovf_2,
  output logic        is_branch,
  output logic [31:0] issue_instr,
  output logic        issue_thread,
  output logic        issue_valid,
  input  logic        issue_ready
`ifdef ISSUE_PERF_CNT_EN
  ,
  output logic [15:0] issued_cnt_1,
  output logic [15:0] issued_cnt_2
`endif
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  function automatic logic is_cf(input logic [6:0] opc);
    case (opc)
      7'b1100011: is_cf = 1'b1;
      7'b1101111: is_cf = 1'b1;
      7'b1100111: is_cf = 1'b1;
      default:    is_cf = 1'b0;
    endcase
  endfunction

  logic [31:0]   mem_1_r [DEPTH];
  logic [31:0]   mem_2_r [DEPTH];
  logic [AW-1:0] wr_ptr_1_r, rd_ptr_1_r, wr_ptr_2_r, rd_ptr_2_r;
  logic [AW:0]   cnt_1_r, cnt_2_r;
  logic [AW+1:0] br_cnt_r;
  logic          ovf_1_r, ovf_2_r, last_thr_r;
  logic          issue_valid_r, issue_thread_r;
  logic [31:0]   issue_instr_r;

  logic          full_1_s, full_2_s, load_s, hs_s, sel_valid_s, sel_thr_s;
  logic          push_1_s, push_2_s, pop_1_s, pop_2_s, drop_1_s, drop_2_s;
  logic          br_inc_s, br_dec_s;
  logic [31:0]   head_s;

  // Push/pop qualification and round-robin source selection.
  always_comb begin
    full_1_s    = (cnt_1_r == FULL_CNT);
    full_2_s    = (cnt_2_r == FULL_CNT);
    load_s      = !issue_valid_r || issue_ready;
    hs_s        = issue_valid_r && issue_ready;
    sel_valid_s = 1'b0;
    sel_thr_s   = last_thr_r;
    if ((cnt_1_r != (AW+1)'(0)) && (cnt_2_r != (AW+1)'(0))) begin
      sel_valid_s = 1'b1;
      sel_thr_s   = !last_thr_r;
    end else if (cnt_1_r != (AW+1)'(0)) begin
      sel_valid_s = 1'b1;
      sel_thr_s   = 1'b0;
    end else if (cnt_2_r != (AW+1)'(0)) begin
      sel_valid_s = 1'b1;
      sel_thr_s   = 1'b1;
    end else begin
      sel_valid_s = 1'b0;
      sel_thr_s   = last_thr_r;
    end
    head_s   = sel_thr_s ? mem_2_r[rd_ptr_2_r] : mem_1_r[rd_ptr_1_r];
    pop_1_s  = load_s && sel_valid_s && !sel_thr_s;
    pop_2_s  = load_s && sel_valid_s && sel_thr_s;
    push_1_s = in_valid && !in_thread && !full_1_s;
    push_2_s = in_valid && in_thread && !full_2_s;
    drop_1_s = in_valid && !in_thread && full_1_s;
    drop_2_s = in_valid && in_thread && full_2_s;
    br_inc_s = push_1_s && is_cf(in_instr[6:0]);
    br_dec_s = hs_s && !issue_thread_r && is_cf(issue_instr_r[6:0]);
  end

  // FIFO storage; contents are don't-care once pointers reset.
  always_ff @(posedge clk) begin
    if (push_1_s) mem_1_r[wr_ptr_1_r] <= in_instr;
    if (push_2_s) mem_2_r[wr_ptr_2_r] <= in_instr;
  end

  // Pointers, counts, sticky overflow and branch tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_1_r <= AW'(0);
      rd_ptr_1_r <= AW'(0);
      wr_ptr_2_r <= AW'(0);
      rd_ptr_2_r <= AW'(0);
      cnt_1_r    <= (AW+1)'(0);
      cnt_2_r    <= (AW+1)'(0);
      ovf_1_r    <= 1'b0;
      ovf_2_r    <= 1'b0;
      br_cnt_r   <= (AW+2)'(0);
    end else begin
      if (push_1_s) wr_ptr_1_r <= wr_ptr_1_r + AW'(1);
      if (pop_1_s)  rd_ptr_1_r <= rd_ptr_1_r + AW'(1);
      if (push_2_s) wr_ptr_2_r <= wr_ptr_2_r + AW'(1);
      if (pop_2_s)  rd_ptr_2_r <= rd_ptr_2_r + AW'(1);
      case ({push_1_s, pop_1_s})
        2'b10:   cnt_1_r <= cnt_1_r + (AW+1)'(1);
        2'b01:   cnt_1_r <= cnt_1_r - (AW+1)'(1);
        default: cnt_1_r <= cnt_1_r;
      endcase
      case ({push_2_s, pop_2_s})
        2'b10:   cnt_2_r <= cnt_2_r + (AW+1)'(1);
        2'b01:   cnt_2_r <= cnt_2_r - (AW+1)'(1);
        default: cnt_2_r <= cnt_2_r;
      endcase
      if (drop_1_s) ovf_1_r <= 1'b1;
      if (drop_2_s) ovf_2_r <= 1'b1;
      case ({br_inc_s, br_dec_s})
        2'b10:   br_cnt_r <= br_cnt_r + (AW+2)'(1);
        2'b01:   br_cnt_r <= br_cnt_r - (AW+2)'(1);
        default: br_cnt_r <= br_cnt_r;
      endcase
    end
  end

  // Output register: loads on empty or handshake, holds while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issue_valid_r  <= 1'b0;
      issue_instr_r  <= 32'd0;
      issue_thread_r <= 1'b0;
      last_thr_r     <= 1'b1;
    end else if (load_s) begin
      if (sel_valid_s) begin
        issue_valid_r  <= 1'b1;
        issue_instr_r  <= head_s;
        issue_thread_r <= sel_thr_s;
        last_thr_r     <= sel_thr_s;
      end else begin
        issue_valid_r  <= 1'b0;
      end
    end
  end

`ifdef ISSUE_PERF_CNT_EN
  logic [15:0] issued_cnt_1_r, issued_cnt_2_r;

  // Per-thread completed-handshake counters, wrapping at 16 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issued_cnt_1_r <= 16'd0;
      issued_cnt_2_r <= 16'd0;
    end else if (hs_s) begin
      if (issue_thread_r) issued_cnt_2_r <= issued_cnt_2_r + 16'd1;
      else                issued_cnt_1_r <= issued_cnt_1_r + 16'd1;
    end
  end

  assign issued_cnt_1 = issued_cnt_1_r;
  assign issued_cnt_2 = issued_cnt_2_r;
`endif

  assign full_1       = full_1_s;
  assign full_2       = full_2_s;
  assign ovf_1        = ovf_1_r;
  assign ovf_2        = ovf_2_r;
  assign is_branch    = (br_cnt_r != (AW+2)'(0));
  assign issue_instr  = issue_instr_r;
  assign issue_thread = issue_thread_r;
  assign issue_valid  = issue_valid_r;

endmodule

// File: tb/tb_thread_issue_queue.sv
// Scoreboard bench for thread_issue_queue: expected instructions queued per thread at push time,
// compared at each output handshake.
module tb_thread_issue_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_instr;
  logic        in_valid, in_thread;
  logic        full_1, full_2, ovf_1, ovf_2, is_branch;
  logic [31:0] issue_instr;
  logic        issue_thread, issue_valid, issue_ready;
`ifdef ISSUE_PERF_CNT_EN
  logic [15:0] issued_cnt_1, issued_cnt_2;
`endif

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] q1[$];
  logic [31:0] q2[$];
  logic [31:0] order_q[$];

  thread_issue_queue #(.DEPTH(4), .AW(2)) dut (
    .clk(clk), .reset(reset), .in_instr(in_instr), .in_valid(in_valid), .in_thread(in_thread),
    .full_1(full_1), .full_2(full_2), .ovf_1(ovf_1), .ovf_2(ovf_2), .is_branch(is_branch),
    .issue_instr(issue_instr), .issue_thread(issue_thread), .issue_valid(issue_valid),
    .issue_ready(issue_ready)
`ifdef ISSUE_PERF_CNT_EN
    , .issued_cnt_1(issued_cnt_1), .issued_cnt_2(issued_cnt_2)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic thr, input logic [31:0] ins, input bit drop);
    in_valid  = 1'b1;
    in_thread = thr;
    in_instr  = ins;
    if (!drop) begin
      if (thr) q2.push_back(ins);
      else     q1.push_back(ins);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    issue_ready = 1'b1;
    while ((q1.size() != 0 || q2.size() != 0 || issue_valid) && n < 60) begin
      tick();
      n++;
    end
    check(tag, 32'(q1.size() + q2.size()), 32'd0);
    check({tag, "_idle"}, {31'd0, issue_valid}, 32'd0);
  endtask

  // Scoreboard: compare each completed handshake against the head of its thread's queue.
  always @(negedge clk) begin
    if (!reset && issue_valid && issue_ready) begin
      order_q.push_back(issue_instr);
      if (issue_thread) begin
        if (q2.size() == 0) check("unexpected_t2", {31'd0, issue_valid}, 32'd0);
        else check("issue_t2", issue_instr, q2.pop_front());
      end else begin
        if (q1.size() == 0) check("unexpected_t1", {31'd0, issue_valid}, 32'd0);
        else check("issue_t1", issue_instr, q1.pop_front());
      end
    end
  end

  initial begin
    logic [31:0] rr_exp [4];
    rr_exp[0] = 32'hA1A1_0013; rr_exp[1] = 32'hB1B1_0013;
    rr_exp[2] = 32'hA2A2_0013; rr_exp[3] = 32'hB2B2_0013;
    reset = 1'b1; in_instr = 32'd0; in_valid = 1'b0; in_thread = 1'b0; issue_ready = 1'b0;
    tick(); tick();
    check("rst_valid", {31'd0, issue_valid}, 32'd0);
    check("rst_instr", issue_instr, 32'd0);
    check("rst_flags", {27'd0, full_1, full_2, ovf_1, ovf_2, is_branch}, 32'd0);
    reset = 1'b0;
    tick();

    // Basic two-edge latency
    issue_ready = 1'b1;
    push(1'b0, 32'h0010_0093, 1'b0);
    check("lat_edge1_valid", {31'd0, issue_valid}, 32'd0);
    tick();
    check("lat_edge2_valid", {31'd0, issue_valid}, 32'd1);
    check("lat_edge2_instr", issue_instr, 32'h0010_0093);
    check("lat_edge2_thread", {31'd0, issue_thread}, 32'd0);
    tick();
    check("lat_after_valid", {31'd0, issue_valid}, 32'd0);

    // Branch flag tracking
    issue_ready = 1'b0;
    push(1'b0, 32'h0000_0063, 1'b0);
    check("br_set", {31'd0, is_branch}, 32'd1);
    tick();
    check("br_held", {31'd0, is_branch}, 32'd1);
    issue_ready = 1'b1;
    tick();
    check("br_clear", {31'd0, is_branch}, 32'd0);
    push(1'b1, 32'h0000_006F, 1'b0);
    check("br_t2_a", {31'd0, is_branch}, 32'd0);
    tick();
    check("br_t2_b", {31'd0, is_branch}, 32'd0);
    drain("br_drain");

    // Round-robin ordering
    issue_ready = 1'b0;
    order_q.delete();
    push(1'b0, rr_exp[0], 1'b0);
    push(1'b0, rr_exp[2], 1'b0);
    push(1'b1, rr_exp[1], 1'b0);
    push(1'b1, rr_exp[3], 1'b0);
    drain("rr_drain");
    check("rr_count", 32'(order_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < order_q.size(); i++) check("rr_order", order_q[i], rr_exp[i]);

    // Overflow on thread 1
    issue_ready = 1'b0;
    check("ovf_pre", {31'd0, ovf_1}, 32'd0);
    for (int i = 1; i <= 5; i++) push(1'b0, 32'h5500_0000 + 32'(i), 1'b0);
    push(1'b0, 32'h5500_0006, 1'b1);
    check("ovf_full_1", {31'd0, full_1}, 32'd1);
    check("ovf_flag_1", {31'd0, ovf_1}, 32'd1);
    check("ovf_flag_2", {31'd0, ovf_2}, 32'd0);
    order_q.delete();
    drain("ovf_drain");
    check("ovf_count", 32'(order_q.size()), 32'd5);
    check("ovf_sticky", {31'd0, ovf_1}, 32'd1);

    // Stall stability
    issue_ready = 1'b0;
    push(1'b1, 32'hCAFE_0013, 1'b0);
    tick();
    for (int i = 0; i < 10; i++) begin
      check("stall_valid", {31'd0, issue_valid}, 32'd1);
      check("stall_instr", issue_instr, 32'hCAFE_0013);
      check("stall_thread", {31'd0, issue_thread}, 32'd1);
      tick();
    end
    drain("stall_drain");

    // Asynchronous reset mid-stream
    issue_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(1'b0, 32'h0000_0063 + (32'(i) << 20), 1'b0);
    check("mid_br_pre", {31'd0, is_branch}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_valid", {31'd0, issue_valid}, 32'd0);
    check("mid_instr", issue_instr, 32'd0);
    check("mid_flags", {27'd0, full_1, full_2, ovf_1, ovf_2, is_branch}, 32'd0);
    q1.delete();
    q2.delete();
    tick();
    reset = 1'b0;
    issue_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("post_rst_idle", {31'd0, issue_valid}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/thread_issue_queue.md
Name: thread_issue_queue

Overview:
- Sits directly downstream of the two-thread instruction arbiter.
- Buffers each arbitrated instruction in a per-thread FIFO, decodes control-flow opcodes, and returns a branch-pending flag to the arbiter so it holds on thread 1.
- Issues buffered instructions to execute through a registered valid/ready stage, using round-robin between threads.

Parameters:
- DEPTH, 4: entries per thread FIFO; power of two, at least 2.
- AW, 2: FIFO pointer width, equal to log2(DEPTH).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous reset, active-high.
- in_instr  in  32  instruction selected by the arbiter.
- in_valid  in  1  in_instr is a new instruction this cycle.
- in_thread  in  1  source thread: 0 = thread 1, 1 = thread 2.
- full_1  out  1  thread-1 FIFO count equals DEPTH.
- full_2  out  1  thread-2 FIFO count equals DEPTH.
- ovf_1  out  1  sticky flag: a thread-1 push was dropped.
- ovf_2  out  1  sticky flag: a thread-2 push was dropped.
- is_branch  out  1  a thread-1 control-flow instruction is held in this block.
- issue_instr  out  32  instruction in the output register.
- issue_thread  out  1  thread tag of issue_instr.
- issue_valid  out  1  output register holds a valid instruction.
- issue_ready  in  1  execute stage accepts the instruction this cycle.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - Both FIFOs empty, pointers 0.
  - issue_valid=0, issue_instr=0, issue_thread=0.
  - ovf_1=ovf_2=0, is_branch=0, full_1=full_2=0.
  - Round-robin pointer last_thr=1, so thread 1 wins first.
  - All buffered instructions are discarded.
- Push:
  - When in_valid=1, in_instr is written to the FIFO selected by in_thread.
  - Full is judged on the registered count. A push to a full FIFO is dropped even if that FIFO pops in the same cycle.
  - A dropped push sets the matching ovf_x to 1 on the next edge; it stays set until reset.
- Pop / output register:
  - The register loads when issue_valid=0, or when issue_valid=1 and issue_ready=1.
  - Source selection:
    - If both FIFOs are non-empty, take the thread opposite last_thr.
    - If only one is non-empty, take that one.
    - If both are empty, issue_valid becomes 0 (when a handshake occurred).
  - On a load: pop the head, issue_valid=1, and set issue_thread and last_thr to the selected thread.
  - While issue_valid=1 and issue_ready=0, issue_instr and issue_thread hold stable.
- Latency:
  - A push into an empty FIFO with an empty, non-stalled output appears on issue_valid on the second edge: one edge to write the FIFO, one to load the output register.
  - No FIFO bypass exists.
  - Peak throughput is 1 instruction per cycle.
- Simultaneous push and pop on the same non-full FIFO: both happen and the count is unchanged.
- Pointers wrap modulo DEPTH. The count is AW+1 bits.
- Control-flow decode uses instr[6:0]:
  - 1100011 (BRANCH), 1101111 (JAL), 1100111 (JALR) are control flow.
  - All other opcodes are not.
- Branch tracking:
  - br_cnt is AW+2 bits.
  - It increments when a thread-1 control-flow instruction is accepted into the FIFO.
  - It decrements when the output handshake (issue_valid and issue_ready) completes on a thread-1 control-flow instruction.
  - If both happen in the same cycle it is unchanged.
  - is_branch = (br_cnt != 0), driven from the register with no combinational path from inputs.
  - Dropped pushes never increment br_cnt.
  - Thread-2 control-flow instructions never affect is_branch.

Optional Feature:
- Macro ISSUE_PERF_CNT_EN.
- When defined, adds outputs issued_cnt_1 and issued_cnt_2 (16 bits each).
  - Each increments on every completed output handshake for its thread.
  - Each wraps from 0xFFFF to 0 and resets to 0.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Basic latency: reset, then push 0x00100093 on thread 0 with issue_ready=1 → issue_valid=1, issue_instr=0x00100093, issue_thread=0 after the second edge; then issue_valid=0.
- Branch flag: push 0x00000063 on thread 0 with issue_ready=0 → is_branch=1 from the next cycle; raise issue_ready → is_branch=0 the cycle after the handshake. Push 0x0000006F on thread 1 → is_branch stays 0.
- Round-robin: fill thread 1 with A1,A2 and thread 2 with B1,B2, then hold issue_ready=1 → issue order A1,B1,A2,B2.
- Overflow: with DEPTH=4 and issue_ready=0, push 6 instructions on thread 1 → after the output register loads one, the FIFO fills; the 6th push is dropped, full_1=1, ovf_1=1. Drain to get exactly 5 instructions in order; ovf_1 remains 1.
- Stall stability: issue_ready=0 for 10 cycles with issue_valid=1 → issue_instr and issue_thread unchanged throughout.
- Reset mid-stream: assert reset with 3 entries queued and is_branch=1 → all outputs are 0 immediately, without waiting for a clock edge. After release, no stale instructions are issued.
